uart_baud_timer: RTL and testbench
==================================

# uart_baud_timer

Parametrised bit-time generator for the full UART: produces one-cycle bit-time-up (btu) strobes spaced by a programmable divisor, for a programmable number of bits, then signals completion. It sits between the transmit/receive control FSMs and their shift registers. It replaces the free-running enable-gated counter with a latched-divisor, start/stop-controlled engine. Its half-bit first-tick mode lets the receiver sample the start bit at mid-bit.

## Interface
- CNT_W, 19, divisor/counter width
- BITS_W, 4, width of bit-count and bit index
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- k  in  CNT_W  bit time in clocks minus one; sampled only on accepted start
- nbits  in  BITS_W  number of btu strobes to generate; sampled on accepted start
- half_first  in  1  1 = first interval is half a bit (receiver mode); sampled on accepted start
- start  in  1  single-cycle request to begin a sequence
- stop  in  1  synchronous abort
- btu  out  1  bit-time-up strobe, one cycle wide
- bit_idx  out  BITS_W  number of btu strobes issued in current/last sequence
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse after final btu of a completed sequence

## Operation
- Registers: state {IDLE, HALF, FULL}, cnt[CNT_W], k_r, n_r, half_r, bit_idx, done.
- target = (state==HALF) ? (k_r >> 1) : k_r (logical shift, CNT_W wide).
- btu = (state != IDLE) && (cnt == target) && !stop; combinational decode of registers only.
- IDLE: cnt=0, busy=0. On start && !stop: latch k, nbits, half_first; bit_idx<=0.
  - nbits==0: stay IDLE, done<=1 next cycle, no btu.
  - else: go HALF if half_first else FULL, cnt<=0.
- HALF/FULL, no stop: if cnt!=target, cnt<=cnt+1. If btu: cnt<=0, bit_idx<=bit_idx+1.
  - bit_idx+1 == n_r: state<=IDLE, done<=1.
  - else: state<=FULL (HALF always exits to FULL).
- stop while busy: state<=IDLE, cnt<=0, no btu that cycle, no done; bit_idx holds.
- Priority: stop > btu > start. start while busy ignored. stop and start in the same cycle in IDLE: start ignored.
- k/nbits/half_first changes while busy: no effect.
- done is registered, high exactly one cycle. Otherwise 0.
- bit_idx holds its value in IDLE until the next accepted start.
- cnt never exceeds target; no wrap past 2^CNT_W-1 (k=all-ones gives period 2^CNT_W).

## Timing
- Reset values: state IDLE, cnt 0, btu 0, done 0, busy 0, bit_idx 0, k_r/n_r/half_r 0.
- busy = (state != IDLE), registered state decode; high the cycle after the accepted start edge.
- Cycle numbering: the start-accept edge ends cycle 0.
  - FULL mode: btu high in cycles 1+k, 2+2k, ..., n(k+1); period k+1.
  - HALF mode: first btu in cycle 1+(k>>1), then every k+1 cycles.
- k=0: btu every cycle from cycle 1. half_first with k in {0,1}: first btu in cycle 1.
- done is high the cycle after the final btu; busy is low in that same cycle.
- Back-to-back: a start in the done cycle is accepted. With zero idle, its first btu follows the previous last btu by at least k+2 cycles.
- Reset mid-sequence: all outputs to reset values immediately (async), no done.

## Test plan
- Reset: assert rst during active count (k=9, nbits=8) -> btu/busy/done/bit_idx go 0 immediately; no btu after release until start.
- TX mode: k=9, nbits=10, half_first=0, start at cycle 0 -> btu in cycles 10,20,...,100; bit_idx 1..10; done in cycle 101; busy cycles 1..100.
- RX mode: k=15, nbits=3, half_first=1 -> btu in cycles 8,24,40; done in cycle 41.
- Edges: k=0, nbits=4 -> btu cycles 1-4, done cycle 5. nbits=0 -> done in cycle 1, no btu, busy stays 0.
- Abort: k=9, nbits=10, stop in cycle 30 (a btu cycle) -> no btu in cycle 30; busy 0 from cycle 31; bit_idx=2; no done.
- Robustness: change k to 3 mid-sequence and pulse start while busy -> spacing stays 10, no restart. Start in the done cycle -> new sequence begins, first btu 10 cycles later.

Source files
------------

// File: rtl/uart_baud_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_timer_if
//  Description : Control/status bundle between UART control FSMs and the
//                bit-time generator.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_baud_timer_if #(
    parameter int CNT_W  = 19,
    parameter int BITS_W = 4
);
    logic [CNT_W-1:0]  k;
    logic [BITS_W-1:0] nbits;
    logic              half_first;
    logic              start;
    logic              stop;
    logic              btu;
    logic [BITS_W-1:0] bit_idx;
    logic              busy;
    logic              done;

    modport master (
        output k, nbits, half_first, start, stop,
        input  btu, bit_idx, busy, done
    );

    modport slave (
        input  k, nbits, half_first, start, stop,
        output btu, bit_idx, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/uart_baud_timer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_timer
//  Description : Latched-divisor bit-time generator; emits nbits one-cycle
//                btu strobes k+1 clocks apart, optional half-bit first tick.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_baud_timer #(
    parameter int CNT_W  = 19,
    parameter int BITS_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    uart_baud_timer_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HALF = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   r_k;
    logic [CNT_W-1:0]   w_k_nxt;
    logic [CNT_W-1:0]   w_target;
    logic [BITS_W-1:0]  r_n;
    logic [BITS_W-1:0]  w_n_nxt;
    logic [BITS_W-1:0]  r_bit_idx;
    logic [BITS_W-1:0]  w_bit_idx_nxt;
    logic [BITS_W-1:0]  w_idx_inc;
    logic               r_done;
    logic               w_done_nxt;
    logic               w_btu;

    // Half-bit interval only applies to the very first tick of a sequence.
    assign w_target  = (r_state == ST_HALF) ? (r_k >> 1) : r_k;
    assign w_btu     = (r_state != ST_IDLE) && (r_cnt == w_target) && !bus.stop;
    assign w_idx_inc = r_bit_idx + BITS_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_k       <= '0;
            r_n       <= '0;
            r_bit_idx <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_k       <= w_k_nxt;
            r_n       <= w_n_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_k_nxt       = r_k;
        w_n_nxt       = r_n;
        w_bit_idx_nxt = r_bit_idx;
        w_done_nxt    = 1'b0;

        if (r_state == ST_IDLE) begin
            w_cnt_nxt = '0;
            if (bus.start && !bus.stop) begin
                w_k_nxt       = bus.k;
                w_n_nxt       = bus.nbits;
                w_bit_idx_nxt = '0;
                // A zero-length request completes immediately without ticking.
                if (bus.nbits == '0) begin
                    w_done_nxt = 1'b1;
                end else begin
                    w_state_nxt = bus.half_first ? ST_HALF : ST_FULL;
                end
            end
        end else if (bus.stop) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else if (w_btu) begin
            w_cnt_nxt     = '0;
            w_bit_idx_nxt = w_idx_inc;
            if (w_idx_inc == r_n) begin
                w_state_nxt = ST_IDLE;
                w_done_nxt  = 1'b1;
            end else begin
                w_state_nxt = ST_FULL;
            end
        end else begin
            // cnt stops at target, so k = all-ones never wraps.
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    assign bus.btu     = w_btu;
    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.done    = r_done;
    assign bus.bit_idx = r_bit_idx;

endmodule
`default_nettype wire

// File: tb/tb_uart_baud_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_baud_timer
//  Description : Scoreboard bench for uart_baud_timer with directed vectors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_baud_timer;

    localparam int CNT_W  = 19;
    localparam int BITS_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        bit is_done;
        int cyc;
        int idx;
        bit busy;
    } exp_t;

    exp_t sb[$];

    uart_baud_timer_if #(.CNT_W(CNT_W), .BITS_W(BITS_W)) bif ();

    uart_baud_timer #(.CNT_W(CNT_W), .BITS_W(BITS_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Expected strobes for a sequence accepted at the edge ending cycle t0.
    task automatic push_seq(input int t0, input int k, input int n, input bit half,
                            input int nbtu, input bit with_done);
        int first;
        first = half ? (1 + (k >> 1)) : (1 + k);
        for (int i = 0; i < nbtu; i++)
            sb.push_back('{1'b0, t0 + first + i * (k + 1), i, 1'b1});
        if (with_done) begin
            if (n == 0) sb.push_back('{1'b1, t0 + 1, 0, 1'b0});
            else        sb.push_back('{1'b1, t0 + first + (n - 1) * (k + 1) + 1, n, 1'b0});
        end
    endtask

    task automatic start_seq(input int k, input int n, input bit half,
                             input int nbtu, input bit with_done, output int t0);
        bif.k          = CNT_W'(k);
        bif.nbits      = BITS_W'(n);
        bif.half_first = half;
        bif.start      = 1'b1;
        t0 = cyc;
        push_seq(t0, k, n, half, nbtu, with_done);
        @(posedge clk); #1;
        bif.start = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, sb.size(), 0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_btu"},     bif.btu,     0);
        chk({tag, "_busy"},    bif.busy,    0);
        chk({tag, "_done"},    bif.done,    0);
        chk({tag, "_bit_idx"}, bif.bit_idx, 0);
    endtask

    // Monitor: pops an expectation whenever the DUT strobes btu or done.
    always @(negedge clk) begin
        if (!rst) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                chk(sb[0].is_done ? "missed_done" : "missed_btu", 0, 1);
                void'(sb.pop_front());
            end
            if (bif.btu || bif.done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", {30'd0, bif.done, bif.btu}, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("strobe_cycle", cyc, e.cyc);
                    chk("strobe_kind", {30'd0, bif.done, bif.btu}, e.is_done ? 2 : 1);
                    chk("strobe_bit_idx", bif.bit_idx, e.idx);
                    chk("strobe_busy", bif.busy, e.busy);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int t0, t1;
        bif.k          = '0;
        bif.nbits      = '0;
        bif.half_first = 1'b0;
        bif.start      = 1'b0;
        bif.stop       = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // TX: k=9, 10 bits
        start_seq(9, 10, 1'b0, 10, 1'b1, t0);
        chk("tx_busy_cycle1", bif.busy, 1);
        drain("tx_drain", 150);
        chk("tx_bit_idx_hold", bif.bit_idx, 10);

        // RX: half-bit first tick
        start_seq(15, 3, 1'b1, 3, 1'b1, t0);
        drain("rx_drain", 80);

        // k=0 ticks every cycle; half mode with k=1
        start_seq(0, 4, 1'b0, 4, 1'b1, t0);
        drain("k0_drain", 20);
        start_seq(1, 2, 1'b1, 2, 1'b1, t0);
        drain("k1_half_drain", 20);

        // nbits=0: done only
        start_seq(5, 0, 1'b0, 0, 1'b1, t0);
        chk("n0_busy", bif.busy, 0);
        drain("n0_drain", 10);

        // Abort on a btu cycle
        start_seq(9, 10, 1'b0, 2, 1'b0, t0);
        wait_cyc(t0 + 30);
        bif.stop = 1'b1;
        #1;
        chk("abort_btu_masked", bif.btu, 0);
        @(posedge clk); #1;
        bif.stop = 1'b0;
        chk("abort_busy", bif.busy, 0);
        chk("abort_bit_idx", bif.bit_idx, 2);
        repeat (25) begin @(posedge clk); #1; end
        chk("abort_queue", sb.size(), 0);

        // Changing k and pulsing start mid-sequence has no effect
        start_seq(9, 4, 1'b0, 4, 1'b1, t0);
        wait_cyc(t0 + 5);
        bif.k     = CNT_W'(3);
        bif.nbits = BITS_W'(2);
        bif.start = 1'b1;
        @(posedge clk); #1;
        bif.start = 1'b0;
        bif.k     = CNT_W'(9);
        drain("robust_drain", 80);

        // Back-to-back: start in the done cycle
        start_seq(9, 2, 1'b0, 2, 1'b1, t0);
        wait_cyc(t0 + 21);
        chk("b2b_done_cycle", bif.done, 1);
        start_seq(9, 1, 1'b0, 1, 1'b1, t1);
        chk("b2b_start_cycle", t1, t0 + 21);
        chk("b2b_busy", bif.busy, 1);
        drain("b2b_drain", 40);

        // Asynchronous reset mid-sequence
        start_seq(9, 8, 1'b0, 2, 1'b0, t0);
        wait_cyc(t0 + 25);
        chk("pre_reset_bit_idx", bif.bit_idx, 2);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        chk("post_reset_busy", bif.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
